// File: rtl/ofdm_cp_remover_pkg.sv
// Shared types and defaults for the OFDM cyclic-prefix remover.
// OFDM_CP_REMOVER_PAD_EN adds the S_PAD state used to zero-fill short symbols.
package ofdm_cp_remover_pkg;

    localparam int LEN_W_DFLT       = 12;
    localparam int CP_LEN_DFLT      = 16;
    localparam int FFT_LEN_DFLT     = 64;
    localparam int SR_CP_LEN_DFLT   = 4;
    localparam int SR_FFT_LEN_DFLT  = 5;
    localparam int ERR_W            = 16;

    typedef enum logic [1:0] {
        S_CP      = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DISCARD = 2'd2
`ifdef OFDM_CP_REMOVER_PAD_EN
        ,
        S_PAD     = 2'd3
`endif
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        if (value == {ERR_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ofdm_cp_remover_ctrl.sv
// Symbol framing FSM: counts CP/payload beats, steers the output register and keeps error counts.
// OFDM_CP_REMOVER_PAD_EN switches short-symbol handling from truncation to zero padding.
module ofdm_cp_remover_ctrl
    import ofdm_cp_remover_pkg::*;
#(
    parameter int LEN_W       = LEN_W_DFLT,
    parameter int DEF_CP_LEN  = CP_LEN_DFLT,
    parameter int DEF_FFT_LEN = FFT_LEN_DFLT
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic [LEN_W-1:0] cp_len_set,
    input  logic [LEN_W-1:0] fft_len_set,
    input  logic             i_tvalid,
    input  logic             i_tlast,
    input  logic             o_tvalid,
    input  logic             o_tready,
    output logic             i_tready,
    output logic             load,
    output logic             load_last,
    output logic             load_zero,
    output logic [ERR_W-1:0] err_short,
    output logic [ERR_W-1:0] err_long
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1'b1);

    state_t           state_r, state_nxt_s;
    logic [LEN_W-1:0] cnt_r, cnt_nxt_s;
    logic [LEN_W-1:0] cp_len_r, fft_len_r;
    logic [LEN_W-1:0] cp_eff_s, fft_eff_s;
    logic [ERR_W-1:0] err_short_r, err_long_r;
    logic             boundary_s, payload_s, out_free_s, ready_s;
    logic             short_inc_s, long_inc_s;

    // At a symbol boundary the shadow settings take effect; otherwise the latched lengths hold.
    assign boundary_s = (state_r == S_CP) && (cnt_r == {LEN_W{1'b0}});
    assign cp_eff_s   = boundary_s ? cp_len_set : cp_len_r;
    assign fft_eff_s  = !boundary_s ? fft_len_r :
                        (fft_len_set == {LEN_W{1'b0}}) ? ONE : fft_len_set;
    assign payload_s  = (state_r == S_PAYLOAD) || (boundary_s && (cp_eff_s == {LEN_W{1'b0}}));
    assign out_free_s = o_tready || !o_tvalid;

    assign i_tready  = ready_s && aresetn;
    assign err_short = err_short_r;
    assign err_long  = err_long_r;

    // Next-state, counter and output-register steering.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ready_s     = 1'b0;
        load        = 1'b0;
        load_last   = 1'b0;
        load_zero   = 1'b0;
        short_inc_s = 1'b0;
        long_inc_s  = 1'b0;
        case (state_r)
            S_CP, S_PAYLOAD: begin
                if (payload_s) begin
                    ready_s = out_free_s;
                    if (i_tvalid && out_free_s) begin
                        load = 1'b1;
                        if (cnt_r == fft_eff_s - ONE) begin
                            load_last   = 1'b1;
                            cnt_nxt_s   = {LEN_W{1'b0}};
                            long_inc_s  = !i_tlast;
                            state_nxt_s = i_tlast ? S_CP : S_DISCARD;
                        end else if (i_tlast) begin
                            short_inc_s = 1'b1;
`ifdef OFDM_CP_REMOVER_PAD_EN
                            state_nxt_s = S_PAD;
                            cnt_nxt_s   = cnt_r + ONE;
`else
                            load_last   = 1'b1;
                            state_nxt_s = S_CP;
                            cnt_nxt_s   = {LEN_W{1'b0}};
`endif
                        end else begin
                            state_nxt_s = S_PAYLOAD;
                            cnt_nxt_s   = cnt_r + ONE;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end else begin
                    ready_s = 1'b1;
                    if (i_tvalid && i_tlast) begin
                        short_inc_s = 1'b1;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                    end else if (i_tvalid && (cnt_r == cp_eff_s - ONE)) begin
                        state_nxt_s = S_PAYLOAD;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                    end else if (i_tvalid) begin
                        cnt_nxt_s = cnt_r + ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
            end
            S_DISCARD: begin
                ready_s = 1'b1;
                if (i_tvalid && i_tlast) begin
                    state_nxt_s = S_CP;
                    cnt_nxt_s   = {LEN_W{1'b0}};
                end else begin
                    state_nxt_s = S_DISCARD;
                end
            end
`ifdef OFDM_CP_REMOVER_PAD_EN
            S_PAD: begin
                if (out_free_s) begin
                    load      = 1'b1;
                    load_zero = 1'b1;
                    if (cnt_r == fft_eff_s - ONE) begin
                        load_last   = 1'b1;
                        state_nxt_s = S_CP;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + ONE;
                    end
                end else begin
                    state_nxt_s = S_PAD;
                end
            end
`endif
            default: begin
                state_nxt_s = S_CP;
                cnt_nxt_s   = {LEN_W{1'b0}};
            end
        endcase
    end

    // State, counters, latched lengths and saturating error counters.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_r     <= S_CP;
            cnt_r       <= {LEN_W{1'b0}};
            cp_len_r    <= LEN_W'(DEF_CP_LEN);
            fft_len_r   <= LEN_W'(DEF_FFT_LEN);
            err_short_r <= {ERR_W{1'b0}};
            err_long_r  <= {ERR_W{1'b0}};
        end else if (clear) begin
            state_r     <= S_CP;
            cnt_r       <= {LEN_W{1'b0}};
            err_short_r <= {ERR_W{1'b0}};
            err_long_r  <= {ERR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (boundary_s) begin
                cp_len_r  <= cp_eff_s;
                fft_len_r <= fft_eff_s;
            end
            if (short_inc_s) begin
                err_short_r <= sat_inc(err_short_r);
            end
            if (long_inc_s) begin
                err_long_r <= sat_inc(err_long_r);
            end
        end
    end

endmodule

// File: rtl/setting_reg.sv
// Single-address settings register: captures data on a strobe matching ADDR.
module setting_reg #(
    parameter logic [7:0]       ADDR      = 8'd0,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] value_r;
    logic             unused_s;

    assign unused_s = ^data_in;
    assign data_out = value_r;

    // Capture the low WIDTH bits on a matching settings write.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            value_r <= RESET_VAL;
        end else if (strobe && (addr == ADDR)) begin
            value_r <= data_in[WIDTH-1:0];
        end else begin
            value_r <= value_r;
        end
    end

endmodule

// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: settings decode, framing control and a single output register.
// Build with OFDM_CP_REMOVER_PAD_EN to zero-pad short symbols to the FFT length.
module ofdm_cp_remover
    import ofdm_cp_remover_pkg::*;
#(
    parameter int SR_CP_LEN   = SR_CP_LEN_DFLT,
    parameter int SR_FFT_LEN  = SR_FFT_LEN_DFLT,
    parameter int LEN_W       = LEN_W_DFLT,
    parameter int DEF_CP_LEN  = CP_LEN_DFLT,
    parameter int DEF_FFT_LEN = FFT_LEN_DFLT
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [15:0] err_short,
    output logic [15:0] err_long
);

    logic [LEN_W-1:0] cp_len_set_s, fft_len_set_s;
    logic             load_s, load_last_s, load_zero_s;
    logic [31:0]      o_tdata_r;
    logic             o_tlast_r, o_tvalid_r;

    setting_reg #(
        .ADDR(8'(SR_CP_LEN)), .WIDTH(LEN_W), .RESET_VAL(LEN_W'(DEF_CP_LEN))
    ) u_sr_cp_len (
        .clk(clk), .aresetn(aresetn), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(cp_len_set_s)
    );

    setting_reg #(
        .ADDR(8'(SR_FFT_LEN)), .WIDTH(LEN_W), .RESET_VAL(LEN_W'(DEF_FFT_LEN))
    ) u_sr_fft_len (
        .clk(clk), .aresetn(aresetn), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(fft_len_set_s)
    );

    ofdm_cp_remover_ctrl #(
        .LEN_W(LEN_W), .DEF_CP_LEN(DEF_CP_LEN), .DEF_FFT_LEN(DEF_FFT_LEN)
    ) u_ctrl (
        .clk(clk), .aresetn(aresetn), .clear(clear),
        .cp_len_set(cp_len_set_s), .fft_len_set(fft_len_set_s),
        .i_tvalid(i_tvalid), .i_tlast(i_tlast),
        .o_tvalid(o_tvalid_r), .o_tready(o_tready),
        .i_tready(i_tready), .load(load_s), .load_last(load_last_s), .load_zero(load_zero_s),
        .err_short(err_short), .err_long(err_long)
    );

    assign o_tdata  = o_tdata_r;
    assign o_tlast  = o_tlast_r;
    assign o_tvalid = o_tvalid_r;

    // Output stage: the control only loads it when empty or draining, so a stalled beat is held intact.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            o_tdata_r  <= 32'd0;
            o_tlast_r  <= 1'b0;
            o_tvalid_r <= 1'b0;
        end else if (load_s) begin
            o_tdata_r  <= load_zero_s ? 32'd0 : i_tdata;
            o_tlast_r  <= load_last_s;
            o_tvalid_r <= 1'b1;
        end else if (o_tready) begin
            o_tlast_r  <= 1'b0;
            o_tvalid_r <= 1'b0;
        end else begin
            o_tdata_r  <= o_tdata_r;
            o_tlast_r  <= o_tlast_r;
            o_tvalid_r <= o_tvalid_r;
        end
    end

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed, table-driven bench for ofdm_cp_remover; input beats carry {symbol id, sample index}.
module tb_ofdm_cp_remover;

    logic        clk, aresetn, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
    logic [15:0] err_short, err_long;

    ofdm_cp_remover dut (
        .clk(clk), .aresetn(aresetn), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .err_short(err_short), .err_long(err_long)
    );

    typedef struct {
        int sym_len;
        int exp_len;
        int exp_first;
        int exp_data_n;
        int exp_short;
        int exp_long;
        int rnd;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    int    rdy_mode = 0;
    beat_t q[$];
    vec_t  vecs[9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // o_tready: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1)      o_tready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2) o_tready = 1'b0;
            else                    o_tready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_tvalid && o_tready) q.push_back('{d: o_tdata, l: o_tlast});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_symbol(input int id, input int len);
        int t;
        for (int i = 0; i < len; i++) begin
            i_tdata  = {id[15:0], i[15:0]};
            i_tlast  = (i == len - 1);
            i_tvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!i_tready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                chk("send_timeout", 32'(i), 32'(len));
                break;
            end
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (q.size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_packet(input string name, input int id, input int exp_len,
                                input int first, input int data_n);
        int          bad = 0;
        int          bad_k = -1;
        int          idx;
        logic [31:0] exp_d;
        logic        exp_l;
        chk({name, "_len"}, 32'(q.size()), 32'(exp_len));
        for (int k = 0; k < q.size() && k < exp_len; k++) begin
            idx   = first + k;
            exp_d = (k < data_n) ? {id[15:0], idx[15:0]} : 32'd0;
            exp_l = (k == exp_len - 1);
            if (q[k].d !== exp_d || q[k].l !== exp_l) begin
                if (bad == 0) bad_k = k;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_beats bad=%0d first_bad=%0d actual=%0h/%0b", name, bad, bad_k,
                     q[bad_k].d, q[bad_k].l);
        end
        q.delete();
    endtask

    task automatic write_setting(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
    endtask

    initial begin
        // sym_len, exp_len, exp_first, exp_data_n, exp_short, exp_long, random ready (cumulative errors)
        vecs[0] = '{80, 64, 16, 64, 0, 0, 0};
        vecs[1] = '{80, 64, 16, 64, 0, 0, 1};
        vecs[2] = '{80, 64, 16, 64, 0, 0, 1};
`ifdef OFDM_CP_REMOVER_PAD_EN
        vecs[3] = '{50, 64, 16, 34, 1, 0, 0};
`else
        vecs[3] = '{50, 34, 16, 34, 1, 0, 0};
`endif
        vecs[4] = '{100, 64, 16, 64, 1, 1, 0};
        vecs[5] = '{80, 64, 16, 64, 1, 1, 1};
        vecs[6] = '{16, 0, 16, 0, 2, 1, 0};
`ifdef OFDM_CP_REMOVER_PAD_EN
        vecs[7] = '{17, 64, 16, 1, 3, 1, 0};
`else
        vecs[7] = '{17, 1, 16, 1, 3, 1, 0};
`endif
        vecs[8] = '{80, 64, 16, 64, 3, 1, 1};

        aresetn = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_tready", 32'(i_tready), 32'd0);
        chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst_o_tdata", o_tdata, 32'd0);
        chk("rst_o_tlast", 32'(o_tlast), 32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        chk("rst_err_long", 32'(err_long), 32'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_i_tready", 32'(i_tready), 32'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            rdy_mode = vecs[v].rnd;
            send_symbol(100 + v, vecs[v].sym_len);
            wait_out(vecs[v].exp_len);
            check_packet($sformatf("vec%0d", v), 100 + v, vecs[v].exp_len,
                         vecs[v].exp_first, vecs[v].exp_data_n);
            chk($sformatf("vec%0d_err_short", v), 32'(err_short), 32'(vecs[v].exp_short));
            chk($sformatf("vec%0d_err_long", v), 32'(err_long), 32'(vecs[v].exp_long));
        end

        rdy_mode = 0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_err_short", 32'(err_short), 32'd0);
        chk("clear_err_long", 32'(err_long), 32'd0);
        @(posedge clk);
        #1;

        // New lengths written mid-symbol only apply from the next symbol
        fork
            send_symbol(20, 80);
            begin
                repeat (40) @(posedge clk);
                #1;
                write_setting(8'd4, 32'd32);
                write_setting(8'd5, 32'd128);
            end
        join
        wait_out(64);
        check_packet("midwrite_old", 20, 64, 16, 64);
        send_symbol(21, 160);
        wait_out(128);
        check_packet("midwrite_new", 21, 128, 32, 128);
        chk("midwrite_err_short", 32'(err_short), 32'd0);

        // cp=0, fft=4: passthrough
        write_setting(8'd4, 32'd0);
        write_setting(8'd5, 32'd4);
        for (int s = 0; s < 3; s++) begin
            send_symbol(30 + s, 4);
            wait_out(4);
            check_packet($sformatf("pass%0d", s), 30 + s, 4, 0, 4);
        end

        // Reset with a stalled output beat pending
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        i_tdata = {16'd40, 16'd0}; i_tvalid = 1'b1; i_tlast = 1'b0;
        @(negedge clk);
        chk("stall_pre_ready", 32'(i_tready), 32'd1);
        @(posedge clk);
        #1;
        i_tdata = {16'd40, 16'd1};
        @(negedge clk);
        chk("stall_o_tvalid", 32'(o_tvalid), 32'd1);
        chk("stall_i_tready", 32'(i_tready), 32'd0);
        chk("stall_hold_data", o_tdata, {16'd40, 16'd0});
        @(posedge clk);
        #1;
        aresetn = 1'b0;
        i_tvalid = 1'b0;
        @(negedge clk);
        chk("rst2_i_tready", 32'(i_tready), 32'd0);
        @(negedge clk);
        chk("rst2_o_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst2_no_leak", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        rdy_mode = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        send_symbol(41, 80);
        wait_out(64);
        check_packet("resync", 41, 64, 16, 64);
        chk("resync_err_short", 32'(err_short), 32'd0);
        chk("resync_err_long", 32'(err_long), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
